uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo.sv | 118 +++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART core and the bus wrapper. A three-state FSM
// drains each byte from the core. The head byte is presented first-word-fall-through.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  uart_ready_i,
  input  logic [DATA_WIDTH-1:0] uart_data_i,
  output logic                  uart_rd_o,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o,
  input  logic                  clr_ovf_i
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    SETTLE
  } state_e;

  state_e                  state_q;
  logic                    uartRd_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG2-1:0]   rdPtr_q, rdPtr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    overflow_q, overflow_d;

  logic isEmpty, isFull, pushReq, pushEn, popEn, dropByte;

  assign isEmpty  = (count_q == '0);
  assign isFull   = (count_q == DEPTH_CNT);
  assign pushReq  = (state_q == IDLE) && uart_ready_i;
  // A full FIFO still accepts the byte when the bus pops in the same cycle.
  assign pushEn   = pushReq && (!isFull || pop_i);
  assign popEn    = pop_i && !isEmpty;
  assign dropByte = pushReq && isFull && !pop_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      uartRd_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (uart_ready_i) begin
            state_q  <= ACK;
            uartRd_q <= 1'b1;
          end
        end
        ACK: begin
          state_q  <= SETTLE;
          uartRd_q <= 1'b0;
        end
        SETTLE: begin
          state_q  <= IDLE;
          uartRd_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          uartRd_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (pushEn) wrPtr_d = wrPtr_q + 1'b1;
    if (popEn)  rdPtr_d = rdPtr_q + 1'b1;
    case ({pushEn, popEn})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (dropByte)       overflow_d = 1'b1;
    else if (clr_ovf_i) overflow_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left unreset; dout_o is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (pushEn) mem_q[wrPtr_q] <= uart_data_i;
  end

  assign uart_rd_o  = uartRd_q;
  assign dout_o     = isEmpty ? '0 : mem_q[rdPtr_q];
  assign empty_o    = isEmpty;
  assign full_o     = isFull;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule
